// File: rtl/complex_eightxeight_feeder.sv
// Collects up to 8 complex elements into adder-tree lanes, fires the tree and holds its result.
// Optional WAIT-state watchdog enabled by defining FEEDER_TIMEOUT_EN.
module complex_eightxeight_feeder #(
    parameter int unsigned NI             = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [63:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              ExE_start,
    output logic [NI*64-1:0]  inputs,
    input  logic [63:0]       summation,
    input  logic              ExE_finish,
    output logic              res_valid,
    output logic [63:0]       res_data,
    input  logic              res_ready,
`ifdef FEEDER_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {StFill, StStart, StWait, StHold} state_e;

    localparam logic [2:0] LastLane = 3'(NI - 1);

    state_e      state_q;
    logic [2:0]  lane_cnt_q;
    logic [63:0] lanes_q [NI];
    logic        exe_start_q;
    logic        res_valid_q;
    logic [63:0] res_data_q;
    logic        accept;

`ifdef FEEDER_TIMEOUT_EN
    logic [31:0] wait_cnt_q;
    logic        timeout_err_q;
`else
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign accept = in_valid && (state_q == StFill);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            lane_cnt_q  <= '0;
            exe_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            for (int unsigned k = 0; k < NI; k++) begin
                lanes_q[k] <= '0;
            end
`ifdef FEEDER_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            exe_start_q <= 1'b0;
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        lanes_q[lane_cnt_q] <= in_data;
                        if (in_last || (lane_cnt_q == LastLane)) begin
                            // Clear stale lanes left over from a longer previous vector
                            for (int unsigned k = 0; k < NI; k++) begin
                                if (k > 32'(lane_cnt_q)) lanes_q[k] <= '0;
                            end
                            lane_cnt_q  <= '0;
                            exe_start_q <= 1'b1;
                            state_q     <= StStart;
                        end else begin
                            lane_cnt_q <= lane_cnt_q + 3'd1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
`ifdef FEEDER_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                StWait: begin
                    if (ExE_finish) begin
                        res_data_q  <= summation;
                        res_valid_q <= 1'b1;
                        state_q     <= StHold;
`ifdef FEEDER_TIMEOUT_EN
                    end else if (wait_cnt_q == TIMEOUT_CYCLES - 1) begin
                        timeout_err_q <= 1'b1;
                        lane_cnt_q    <= '0;
                        state_q       <= StFill;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
                    end
                end
                StHold: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        lane_cnt_q  <= '0;
                        state_q     <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_lanes
        assign inputs[64*g +: 64] = lanes_q[g];
    end

    assign in_ready  = (state_q == StFill);
    assign busy      = (state_q != StFill);
    assign ExE_start = exe_start_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
`ifdef FEEDER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_complex_eightxeight_feeder.sv
// Directed bench for complex_eightxeight_feeder; watchdog scenario runs when FEEDER_TIMEOUT_EN is set.
module tb_complex_eightxeight_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_last;
    logic         in_ready;
    logic         ExE_start;
    logic [511:0] inputs;
    logic [63:0]  summation;
    logic         ExE_finish;
    logic         res_valid;
    logic [63:0]  res_data;
    logic         res_ready;
    logic         busy;
`ifdef FEEDER_TIMEOUT_EN
    logic         timeout_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    complex_eightxeight_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .ExE_start  (ExE_start),
        .inputs     (inputs),
        .summation  (summation),
        .ExE_finish (ExE_finish),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
`ifdef FEEDER_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        summation  = '0;
        ExE_finish = 1'b0;
        res_ready  = 1'b0;
    endtask

    // Assumes the DUT is in WAIT: returns a result and completes the handshake.
    task automatic finish_and_drain(input logic [63:0] sum);
        ExE_finish = 1'b1;
        summation  = sum;
        tick();
        ExE_finish = 1'b0;
        res_ready  = 1'b1;
        tick();
        res_ready  = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if ({in_ready, busy, ExE_start, res_valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 1000", {in_ready, busy, ExE_start, res_valid});
        end
        n_checks++;
        if (res_data !== 64'd0 || inputs !== 512'd0) begin
            n_fail++;
            $display("FAIL reset_data: got res_data=%h inputs=%h expected zeros", res_data, inputs);
        end
`ifdef FEEDER_TIMEOUT_EN
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_timeout_err: got %b expected 0", timeout_err);
        end
`endif
    endtask

    task automatic test_full_vector();
        logic [511:0] exp_lanes;
        for (int i = 0; i < 8; i++) begin
            exp_lanes[64*i +: 64] = 64'(i + 1);
            in_valid = 1'b1;
            in_data  = 64'(i + 1);
            in_last  = 1'b0;
            tick();
            if (i == 6) begin
                n_checks++;
                if (ExE_start !== 1'b0 || in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_mid: got start=%b ready=%b expected 0 1", ExE_start, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (ExE_start !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_start: got start=%b ready=%b expected 1 0", ExE_start, in_ready);
        end
        n_checks++;
        if (inputs !== exp_lanes) begin
            n_fail++;
            $display("FAIL full_lanes: got %h expected %h", inputs, exp_lanes);
        end
        tick();
        n_checks++;
        if (ExE_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL full_wait: got start=%b busy=%b expected 0 1", ExE_start, busy);
        end
        ExE_finish = 1'b1;
        summation  = 64'd36;
        tick();
        ExE_finish = 1'b0;
        summation  = 64'd0;
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== 64'd36 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_result: got valid=%b data=%0d ready=%b expected 1 36 0",
                     res_valid, res_data, in_ready);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drain: got valid=%b ready=%b expected 0 1", res_valid, in_ready);
        end
    endtask

    task automatic test_short_vector();
        logic [511:0] exp_lanes;
        int           pulses;
        exp_lanes = '0;
        for (int i = 0; i < 3; i++) begin
            exp_lanes[64*i +: 64] = 64'((i + 1) * 256);
            in_valid = 1'b1;
            in_data  = 64'((i + 1) * 256);
            in_last  = (i == 2);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 5; c++) begin
            if (ExE_start === 1'b1) pulses++;
            if (c < 4) tick();
        end
        n_checks++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL short_start_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (inputs !== exp_lanes) begin
            n_fail++;
            $display("FAIL short_lanes: got %h expected %h", inputs, exp_lanes);
        end
        finish_and_drain(64'd1536);
    endtask

    task automatic test_backpressure();
        logic [63:0] sum;
        sum = 64'hDEAD_BEEF_0123_4567;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i + 16);
            tick();
        end
        in_valid = 1'b0;
        tick();
        ExE_finish = 1'b1;
        summation  = sum;
        tick();
        ExE_finish = 1'b0;
        summation  = 64'd0;
        in_valid   = 1'b1;
        in_data    = 64'hAA;
        in_last    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (res_valid !== 1'b1 || res_data !== sum || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_c%0d: got valid=%b data=%h ready=%b expected 1 %h 0",
                         c, res_valid, res_data, in_ready, sum);
            end
            tick();
        end
        // Upstream still offering a last element on the handshake cycle
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_no_accept: got valid=%b busy=%b ready=%b expected 0 0 1",
                     res_valid, busy, in_ready);
        end
    endtask

    task automatic test_spurious_finish();
        logic [511:0] exp_lanes;
        exp_lanes = '0;
        exp_lanes[63:0]    = 64'h11;
        exp_lanes[127:64]  = 64'h22;
        exp_lanes[191:128] = 64'h33;
        in_valid = 1'b1;
        in_data  = 64'h11;
        tick();
        in_data  = 64'h22;
        tick();
        in_valid   = 1'b0;
        ExE_finish = 1'b1;
        summation  = 64'h99;
        tick();
        ExE_finish = 1'b0;
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data === 64'h99) begin
            n_fail++;
            $display("FAIL spurious_finish: got valid=%b busy=%b data=%h expected 0 0 not-99",
                     res_valid, busy, res_data);
        end
        in_valid = 1'b1;
        in_data  = 64'h33;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (inputs !== exp_lanes || ExE_start !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_lane_cnt: got start=%b lanes=%h expected 1 %h",
                     ExE_start, inputs, exp_lanes);
        end
        tick();
        finish_and_drain(64'h66);
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1;
        in_data  = 64'h55;
        in_last  = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || inputs !== 512'd0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_state: got ready=%b valid=%b lanes=%h expected 1 0 zeros",
                     in_ready, res_valid, inputs);
        end
        ExE_finish = 1'b1;
        summation  = 64'h77;
        tick();
        ExE_finish = 1'b0;
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || res_data !== 64'd0) begin
            n_fail++;
            $display("FAIL late_finish: got valid=%b ready=%b data=%h expected 0 1 0",
                     res_valid, in_ready, res_data);
        end
    endtask

`ifdef FEEDER_TIMEOUT_EN
    task automatic test_watchdog();
        int   cycles;
        logic saw_valid;
        in_valid = 1'b1;
        in_data  = 64'h42;
        in_last  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        cycles    = 0;
        saw_valid = 1'b0;
        while (in_ready !== 1'b1 && cycles < 400) begin
            if (res_valid === 1'b1) saw_valid = 1'b1;
            if (cycles == 200) begin
                n_checks++;
                if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL watchdog_early: got err=%b busy=%b expected 0 1",
                             timeout_err, busy);
                end
            end
            tick();
            cycles++;
        end
        n_checks++;
        if (cycles < 255 || cycles > 257) begin
            n_fail++;
            $display("FAIL watchdog_latency: got %0d cycles expected 255..257", cycles);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || saw_valid || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL watchdog_flag: got err=%b saw_valid=%b expected 1 0",
                     timeout_err, saw_valid);
        end
        tick();
        tick();
        n_checks++;
        if (timeout_err !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL watchdog_sticky: got err=%b ready=%b expected 1 1", timeout_err, in_ready);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        drive_idle();
        test_reset();
        test_full_vector();
        test_short_vector();
        test_backpressure();
        test_spurious_finish();
        test_reset_mid_wait();
`ifdef FEEDER_TIMEOUT_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
